// File: rtl/alu_pkg.sv
// Shared encodings for the ALU arbiter: ALU command codes and arbiter FSM states.
// Imported by the arbiter interface, top level and bench.
package alu_pkg;

   typedef enum logic [2:0] {
      CMD_ADD  = 3'd0,
      CMD_SUB  = 3'd1,
      CMD_XOR  = 3'd2,
      CMD_SLT  = 3'd3,
      CMD_AND  = 3'd4,
      CMD_NAND = 3'd5,
      CMD_NOR  = 3'd6,
      CMD_OR   = 3'd7
   } alu_cmd_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   localparam int OPS_W = 16;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, ALU and response signals around the shared ALU.
// slave = arbiter view, master = requesters + ALU + response consumer.
interface alu_arbiter_if
   import alu_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32,
   parameter int IDW   = 2
);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_opa;
   logic [NREQ*WIDTH-1:0] req_opb;
   logic [NREQ*3-1:0]     req_cmd;
   logic [WIDTH-1:0]      alu_opa;
   logic [WIDTH-1:0]      alu_opb;
   logic [2:0]            alu_cmd;
   logic [WIDTH-1:0]      alu_result;
   logic                  resp_valid;
   logic [IDW-1:0]        resp_id;
   logic [WIDTH-1:0]      resp_data;
   logic                  resp_ready;
   logic                  busy;
   logic [OPS_W-1:0]      ops_done;

   modport slave (
      input  req_valid, req_opa, req_opb, req_cmd, alu_result, resp_ready,
      output req_ready, alu_opa, alu_opb, alu_cmd, resp_valid, resp_id, resp_data,
             busy, ops_done
   );

   modport master (
      output req_valid, req_opa, req_opb, req_cmd, alu_result, resp_ready,
      input  req_ready, alu_opa, alu_opb, alu_cmd, resp_valid, resp_id, resp_data,
             busy, ops_done
   );

endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request strictly after last_grant, with wrap.
// Zero latency; gnt is all-zero when no request is set.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last_grant,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_idx
);

   logic found;
   int   cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = 0;
      // k = NREQ revisits last_grant itself, so a lone requester is never starved
      for (int k = 1; k <= NREQ; k++) begin
         cand = (int'(last_grant) + k) % NREQ;
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = IDW'(cand);
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU; accept -> response valid two edges later.
// req_ready only pulses in IDLE; the response is held until resp_ready.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32,
   parameter int IDW   = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_arbiter_if.slave bus
);

   arb_state_e        state_q, state_d;
   logic [WIDTH-1:0]  alu_opa_q, alu_opa_d;
   logic [WIDTH-1:0]  alu_opb_q, alu_opb_d;
   logic [2:0]        alu_cmd_q, alu_cmd_d;
   logic              resp_valid_q, resp_valid_d;
   logic [IDW-1:0]    resp_id_q, resp_id_d;
   logic [WIDTH-1:0]  resp_data_q, resp_data_d;
   logic [OPS_W-1:0]  ops_done_q, ops_done_d;
   logic [IDW-1:0]    last_grant_q, last_grant_d;

   logic [NREQ-1:0]   pick_gnt;
   logic [IDW-1:0]    pick_idx;
   logic [NREQ-1:0]   req_ready;
   int                pick_base;

   rr_pick #(
      .NREQ(NREQ),
      .IDW (IDW)
   ) u_pick (
      .req       (bus.req_valid),
      .last_grant(last_grant_q),
      .gnt       (pick_gnt),
      .gnt_idx   (pick_idx)
   );

   always_comb begin
      state_d      = state_q;
      alu_opa_d    = alu_opa_q;
      alu_opb_d    = alu_opb_q;
      alu_cmd_d    = alu_cmd_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_data_d  = resp_data_q;
      ops_done_d   = ops_done_q;
      last_grant_d = last_grant_q;
      req_ready    = '0;
      pick_base    = int'(pick_idx);

      unique case (state_q)
         IDLE: begin
            if (|bus.req_valid) begin
               // the strobe must stay low while reset holds the FSM in IDLE
               req_ready = rst_n ? pick_gnt : '0;
               alu_opa_d = bus.req_opa[pick_base*WIDTH +: WIDTH];
               alu_opb_d = bus.req_opb[pick_base*WIDTH +: WIDTH];
               alu_cmd_d = bus.req_cmd[pick_base*3 +: 3];
               resp_id_d = pick_idx;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            resp_data_d  = bus.alu_result;
            resp_valid_d = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
               last_grant_d = resp_id_q;
               ops_done_d   = OPS_W'(ops_done_q + 1'b1);
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         alu_opa_q    <= '0;
         alu_opb_q    <= '0;
         alu_cmd_q    <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_data_q  <= '0;
         ops_done_q   <= '0;
         last_grant_q <= IDW'(NREQ - 1);
      end else begin
         state_q      <= state_d;
         alu_opa_q    <= alu_opa_d;
         alu_opb_q    <= alu_opb_d;
         alu_cmd_q    <= alu_cmd_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_data_q  <= resp_data_d;
         ops_done_q   <= ops_done_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.alu_opa    = alu_opa_q;
   assign bus.alu_opb    = alu_opb_q;
   assign bus.alu_cmd    = alu_cmd_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.busy       = (state_q == EXEC) || (state_q == RESP);
   assign bus.ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a cycle model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int NREQ  = 4;
   localparam int WIDTH = 32;
   localparam int IDW   = 2;

   logic clk;
   logic rst_n;

   alu_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

   alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int          n_checks;
   int          n_fail;
   logic [31:0] pa [NREQ];
   logic [31:0] pb [NREQ];
   logic [2:0]  pc [NREQ];
   bit          pv [NREQ];
   int          last_g;
   int          m_phase;
   int          m_id;
   logic [31:0] m_res;
   logic [15:0] exp_ops;
   int          dut_grants[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
      case (c)
         CMD_ADD:  return a + b;
         CMD_SUB:  return a - b;
         CMD_XOR:  return a ^ b;
         CMD_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         CMD_AND:  return a & b;
         CMD_NAND: return ~(a & b);
         CMD_NOR:  return ~(a | b);
         default:  return a | b;
      endcase
   endfunction

   // the external combinational ALU
   always_comb bus.alu_result = alu_fn(bus.alu_opa, bus.alu_opb, bus.alu_cmd);

   function automatic int oh_idx(input logic [NREQ-1:0] v);
      int r;
      r = -1;
      if ($onehot(v)) begin
         for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
      end
      return r;
   endfunction

   task automatic drive_reqs();
      for (int i = 0; i < NREQ; i++) begin
         bus.req_valid[i]               = pv[i];
         bus.req_opa[i*WIDTH +: WIDTH]  = pa[i];
         bus.req_opb[i*WIDTH +: WIDTH]  = pb[i];
         bus.req_cmd[i*3 +: 3]          = pc[i];
      end
   endtask

   task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] c);
      pv[id] = 1'b1;
      pa[id] = a;
      pb[id] = b;
      pc[id] = c;
   endtask

   task automatic rand_payload(input int id);
      pa[id] = $urandom;
      pb[id] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      pc[id] = 3'($urandom_range(0, 7));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
      drive_reqs();
      bus.resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      last_g  = NREQ - 1;
      exp_ops = '0;
      m_phase = 0;
   endtask

   // Issues one request and completes its response; ok=0 when no response arrives in time.
   task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c, output logic [31:0] data, output int rid,
                         output bit ok);
      bit drop;
      ok   = 1'b0;
      drop = 1'b0;
      data = '0;
      rid  = -1;
      @(negedge clk);
      set_req(id, a, b, c);
      drive_reqs();
      #1;
      for (int n = 0; n < 12 && !ok; n++) begin
         if (bus.req_ready[id]) drop = 1'b1;
         if (bus.resp_valid) begin
            data = bus.resp_data;
            rid  = int'(bus.resp_id);
            bus.resp_ready = 1'b1;
            @(negedge clk);
            bus.resp_ready = 1'b0;
            #1;
            ok = 1'b1;
         end else begin
            @(negedge clk);
            if (drop) begin
               pv[id] = 1'b0;
               drive_reqs();
            end
            #1;
         end
      end
      pv[id] = 1'b0;
      drive_reqs();
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         pv[i] = 1'b0; pa[i] = '0; pb[i] = '0; pc[i] = '0;
      end
      drive_reqs();
      bus.resp_ready = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.req_ready, bus.busy, bus.resp_valid} !== '0) begin
         n_fail++;
         $display("FAIL reset_ctrl got rdy=%b busy=%b rv=%b exp all 0", bus.req_ready, bus.busy, bus.resp_valid);
      end
      n_checks++;
      if ({bus.alu_opa, bus.alu_opb, bus.alu_cmd} !== '0) begin
         n_fail++;
         $display("FAIL reset_alu got a=%h b=%h c=%0d exp 0", bus.alu_opa, bus.alu_opb, bus.alu_cmd);
      end
      n_checks++;
      if ({bus.resp_id, bus.resp_data, bus.ops_done} !== '0) begin
         n_fail++;
         $display("FAIL reset_resp got id=%0d data=%h ops=%0d exp 0", bus.resp_id, bus.resp_data, bus.ops_done);
      end
   endtask

   task automatic test_single();
      do_reset();
      @(negedge clk);
      set_req(0, 32'd5, 32'd7, CMD_ADD);
      drive_reqs();
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0001 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_accept got rdy=%b busy=%b exp 0001/0", bus.req_ready, bus.busy);
      end
      @(negedge clk);
      pv[0] = 1'b0;
      drive_reqs();
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_exec got rdy=%b busy=%b exp 0000/1", bus.req_ready, bus.busy);
      end
      n_checks++;
      if (bus.alu_opa !== 32'd5 || bus.alu_opb !== 32'd7 || bus.alu_cmd !== 3'd0) begin
         n_fail++;
         $display("FAIL single_alu got a=%0d b=%0d c=%0d exp 5/7/0", bus.alu_opa, bus.alu_opb, bus.alu_cmd);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0 || bus.resp_data !== 32'd12) begin
         n_fail++;
         $display("FAIL single_resp got v=%b id=%0d data=%0d exp 1/0/12", bus.resp_valid, bus.resp_id, bus.resp_data);
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      #1;
      n_checks++;
      if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.ops_done !== 16'd1) begin
         n_fail++;
         $display("FAIL single_done got v=%b busy=%b ops=%0d exp 0/0/1", bus.resp_valid, bus.busy, bus.ops_done);
      end
      n_checks++;
      if (bus.alu_opa !== 32'd5 || bus.alu_cmd !== 3'd0) begin
         n_fail++;
         $display("FAIL single_hold_alu got a=%0d c=%0d exp 5/0", bus.alu_opa, bus.alu_cmd);
      end
   endtask

   // Cycle model: IDLE grants the first valid requester after last_g, two edges to a response.
   task automatic run_model(input int cycles, input bit all_on);
      int              acc;
      int              win;
      int              j;
      logic [NREQ-1:0] exp_rdy;
      acc = -1;
      for (int cyc = 0; cyc < cycles; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            if (i == acc) begin
               pv[i] = all_on;
               if (all_on) rand_payload(i);
            end else if (!pv[i]) begin
               if (all_on || $urandom_range(0, 2) == 0) begin
                  pv[i] = 1'b1;
                  rand_payload(i);
               end
            end else if (!all_on && $urandom_range(0, 15) == 0) begin
               pv[i] = 1'b0;
            end
         end
         drive_reqs();
         bus.resp_ready = all_on ? 1'b1 : 1'($urandom_range(0, 1));
         #1;
         win     = -1;
         exp_rdy = '0;
         if (m_phase == 0) begin
            for (int k = 1; k <= NREQ; k++) begin
               j = (last_g + k) % NREQ;
               if (win < 0 && pv[j]) win = j;
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
         end
         n_checks++;
         if (bus.req_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL model_req_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_rdy);
         end
         if (bus.req_ready != '0) dut_grants.push_back(oh_idx(bus.req_ready));
         n_checks++;
         if (bus.busy !== (m_phase != 0)) begin
            n_fail++;
            $display("FAIL model_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, (m_phase != 0));
         end
         n_checks++;
         if (bus.resp_valid !== (m_phase == 2)) begin
            n_fail++;
            $display("FAIL model_resp_valid cyc=%0d got=%b exp=%b", cyc, bus.resp_valid, (m_phase == 2));
         end
         n_checks++;
         if (bus.ops_done !== exp_ops) begin
            n_fail++;
            $display("FAIL model_ops_done cyc=%0d got=%0d exp=%0d", cyc, bus.ops_done, exp_ops);
         end
         if (m_phase == 2) begin
            n_checks++;
            if (bus.resp_id !== IDW'(m_id) || bus.resp_data !== m_res) begin
               n_fail++;
               $display("FAIL model_resp cyc=%0d got id=%0d data=%h exp id=%0d data=%h",
                        cyc, bus.resp_id, bus.resp_data, m_id, m_res);
            end
         end
         acc = -1;
         case (m_phase)
            0: if (win >= 0) begin
                  m_id    = win;
                  m_res   = alu_fn(pa[win], pb[win], pc[win]);
                  m_phase = 1;
                  acc     = win;
               end
            1: m_phase = 2;
            default: if (bus.resp_ready) begin
                  exp_ops = exp_ops + 16'd1;
                  last_g  = m_id;
                  m_phase = 0;
               end
         endcase
      end
   endtask

   task automatic test_all_four();
      int exp_order[6];
      int got;
      exp_order = '{0, 1, 2, 3, 0, 1};
      do_reset();
      dut_grants.delete();
      run_model(18, 1'b1);
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
      drive_reqs();
      bus.resp_ready = 1'b0;
      #1;
      n_checks++;
      if (bus.ops_done !== 16'd6) begin
         n_fail++;
         $display("FAIL all_four_ops got=%0d exp=6", bus.ops_done);
      end
      for (int i = 0; i < 6; i++) begin
         got = (i < dut_grants.size()) ? dut_grants[i] : -1;
         n_checks++;
         if (got != exp_order[i]) begin
            n_fail++;
            $display("FAIL all_four_order[%0d] got=%0d exp=%0d", i, got, exp_order[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      @(negedge clk);
      set_req(2, 32'hFF00_FF00, 32'h0F0F_0F0F, CMD_XOR);
      drive_reqs();
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0100) begin
         n_fail++;
         $display("FAIL bp_accept got=%b exp=0100", bus.req_ready);
      end
      @(negedge clk);
      pv[2] = 1'b0;
      set_req(0, 32'd3, 32'd4, CMD_ADD);
      set_req(1, 32'd10, 32'd3, CMD_SUB);
      drive_reqs();
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b1 || bus.alu_cmd !== 3'd2) begin
         n_fail++;
         $display("FAIL bp_exec got rdy=%b busy=%b cmd=%0d exp 0000/1/2", bus.req_ready, bus.busy, bus.alu_cmd);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         n_checks++;
         if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'hF00F_F00F || bus.resp_id !== 2'd2
             || bus.busy !== 1'b1 || bus.req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_hold[%0d] got v=%b data=%h id=%0d busy=%b rdy=%b exp 1/f00ff00f/2/1/0000",
                     i, bus.resp_valid, bus.resp_data, bus.resp_id, bus.busy, bus.req_ready);
         end
      end
      @(negedge clk);
      bus.resp_ready = 1'b1;
      pv[1] = 1'b0;
      drive_reqs();
      #1;
      n_checks++;
      if (bus.resp_valid !== 1'b1 || bus.req_ready !== 4'b0000) begin
         n_fail++;
         $display("FAIL bp_release got v=%b rdy=%b exp 1/0000", bus.resp_valid, bus.req_ready);
      end
      @(negedge clk);
      bus.resp_ready = 1'b0;
      #1;
      n_checks++;
      if (bus.resp_valid !== 1'b0 || bus.ops_done !== 16'd1 || bus.req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL bp_next_arb got v=%b ops=%0d rdy=%b exp 0/1/0001", bus.resp_valid, bus.ops_done, bus.req_ready);
      end
      @(negedge clk);
      pv[0] = 1'b0;
      drive_reqs();
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0 || bus.resp_data !== 32'd7) begin
         n_fail++;
         $display("FAIL bp_second got v=%b id=%0d data=%0d exp 1/0/7", bus.resp_valid, bus.resp_id, bus.resp_data);
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
   endtask

   task automatic test_rr_resume();
      logic [31:0] data;
      int          rid;
      bit          ok;
      do_reset();
      run_op(1, 32'd100, 32'd1, CMD_SUB, data, rid, ok);
      n_checks++;
      if (!ok || rid != 1 || data !== 32'd99) begin
         n_fail++;
         $display("FAIL rr_first got ok=%0d id=%0d data=%0d exp 1/1/99", ok, rid, data);
      end
      @(negedge clk);
      set_req(0, 32'h0000_00F0, 32'h0000_000F, CMD_OR);
      set_req(3, 32'h0, 32'h0, CMD_NOR);
      drive_reqs();
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b1000) begin
         n_fail++;
         $display("FAIL rr_pick3 got=%b exp=1000", bus.req_ready);
      end
      @(negedge clk);
      pv[3] = 1'b0;
      drive_reqs();
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.resp_id !== 2'd3 || bus.resp_data !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL rr_resp3 got id=%0d data=%h exp 3/ffffffff", bus.resp_id, bus.resp_data);
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL rr_pick0 got=%b exp=0001", bus.req_ready);
      end
      @(negedge clk);
      pv[0] = 1'b0;
      drive_reqs();
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.resp_id !== 2'd0 || bus.resp_data !== 32'h0000_00FF) begin
         n_fail++;
         $display("FAIL rr_resp0 got id=%0d data=%h exp 0/000000ff", bus.resp_id, bus.resp_data);
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(negedge clk);
      set_req(1, 32'hFFFF_0000, 32'h1234_5678, CMD_AND);
      drive_reqs();
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL rst_mid_accept got=%b exp=0010", bus.req_ready);
      end
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.req_ready, bus.busy, bus.resp_valid, bus.alu_cmd} !== '0
          || {bus.alu_opa, bus.alu_opb} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_ctrl got rdy=%b busy=%b v=%b a=%h b=%h c=%0d exp all 0",
                  bus.req_ready, bus.busy, bus.resp_valid, bus.alu_opa, bus.alu_opb, bus.alu_cmd);
      end
      n_checks++;
      if ({bus.resp_id, bus.resp_data, bus.ops_done} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_resp got id=%0d data=%h ops=%0d exp 0", bus.resp_id, bus.resp_data, bus.ops_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL rst_mid_reaccept got=%b exp=0010", bus.req_ready);
      end
      @(negedge clk);
      pv[1] = 1'b0;
      drive_reqs();
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd1 || bus.resp_data !== 32'h1234_0000) begin
         n_fail++;
         $display("FAIL rst_mid_resp2 got v=%b id=%0d data=%h exp 1/1/12340000", bus.resp_valid, bus.resp_id, bus.resp_data);
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      #1;
      n_checks++;
      if (bus.ops_done !== 16'd1) begin
         n_fail++;
         $display("FAIL rst_mid_ops got=%0d exp=1", bus.ops_done);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] data;
      int          rid;
      bit          ok;
      do_reset();
      @(negedge clk);
      force dut.ops_done_q = 16'hFFFE;
      #1;
      release dut.ops_done_q;
      #1;
      n_checks++;
      if (bus.ops_done !== 16'hFFFE) begin
         n_fail++;
         $display("FAIL wrap_preload got=%h exp=fffe", bus.ops_done);
      end
      run_op(2, 32'hFFFF_FFFB, 32'd3, CMD_SLT, data, rid, ok);
      n_checks++;
      if (!ok || data !== 32'd1 || bus.ops_done !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL wrap_ffff got ok=%0d data=%h ops=%h exp 1/1/ffff", ok, data, bus.ops_done);
      end
      run_op(0, 32'd3, 32'hFFFF_FFFB, CMD_SLT, data, rid, ok);
      n_checks++;
      if (!ok || data !== 32'd0 || bus.ops_done !== 16'h0000) begin
         n_fail++;
         $display("FAIL wrap_zero got ok=%0d data=%h ops=%h exp 1/0/0000", ok, data, bus.ops_done);
      end
      run_op(3, 32'hF0F0_F0F0, 32'hFF00_FF00, CMD_NAND, data, rid, ok);
      n_checks++;
      if (!ok || rid != 3 || data !== 32'h0FFF_0FFF || bus.ops_done !== 16'h0001) begin
         n_fail++;
         $display("FAIL wrap_one got ok=%0d id=%0d data=%h ops=%h exp 1/3/0fff0fff/0001", ok, rid, data, bus.ops_done);
      end
   endtask

   task automatic test_random();
      do_reset();
      run_model(600, 1'b0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_single();
      test_all_four();
      test_backpressure();
      test_rr_resume();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired before the test sequence completed");
      $fatal(1, "watchdog");
   end

endmodule
